// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: grants the shared bus to one of NUM_MASTERS wrappers (0 = instruction fetch).
// Latency: HGrant one cycle after HReq in IDLE; handovers land on the HReady=1 edge; HMaster follows one HReady=1 cycle later.
// Backpressure: HReady=0 freezes all grant/owner state; optional ARB_ROUND_ROBIN_EN macro selects round-robin winners.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int MAX_HOLD       = 16,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         HReq,
  input  logic [NUM_MASTERS-1:0]         HLock,
  input  logic                           HReady,
  input  logic [1:0]                     HResp,
  output logic [NUM_MASTERS-1:0]         HGrant,
  output logic [$clog2(NUM_MASTERS)-1:0] HMaster,
  output logic                           HMastLock,
  output logic                           arb_busy
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, OWN, ERR} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          master_q, master_d;
  logic                   mlock_q, mlock_d;

  logic [NUM_MASTERS-1:0] others;
  logic [HW-1:0]          hold_inc;
  logic [IW-1:0]          start_idx;
  logic [IW:0]            win_all;
  logic [IW:0]            win_oth;

  // Returns {found, index} of the first requester scanning upward from start, wrapping.
  function automatic logic [IW:0] pick(input logic [NUM_MASTERS-1:0] req,
                                       input logic [IW-1:0] start);
    logic [IW:0]            res;
    logic [NUM_MASTERS-1:0] sh;
    int                     j;
    res = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      j  = (int'(start) + i) % NUM_MASTERS;
      sh = req >> j;
      if (sh[0]) res = {1'b1, IW'(j)};
    end
    return res;
  endfunction

  // Winner search origin: index after the last owner for round-robin, else index 0.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    start_idx = (owner_q == IW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
`else
    start_idx = '0;
`endif
  end

  // Next-state, owner, hold counter and registered output values.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    grant_d  = grant_q;
    master_d = master_q;
    mlock_d  = mlock_q;

    others   = HReq & ~(NUM_MASTERS'(1) << owner_q);
    hold_inc = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
    win_all  = pick(HReq, start_idx);
    win_oth  = pick(others, start_idx);

    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (HReady && win_all[IW]) begin
          state_d = OWN;
          owner_d = win_all[IW-1:0];
        end
      end
      OWN: begin
        if (HReady) begin
          if (HLock[owner_q]) begin
            // Locked owner keeps the bus; the counter still runs so a
            // handover is due as soon as the lock drops.
            hold_d = (|others) ? hold_inc : '0;
          end else if (!HReq[owner_q]) begin
            hold_d = '0;
            if (win_all[IW]) owner_d = win_all[IW-1:0];
            else             state_d = IDLE;
          end else if ((|others) && (hold_inc == HW'(MAX_HOLD))) begin
            hold_d  = '0;
            owner_d = win_oth[IW-1:0];
          end else begin
            hold_d = (|others) ? hold_inc : '0;
          end
        end else if (HResp == 2'b01) begin
          state_d = ERR;
        end
      end
      ERR: begin
        // Second ERROR cycle: treat the owner as released, even if still requesting.
        if (HReady) begin
          hold_d = '0;
          if (win_oth[IW]) begin
            state_d = OWN;
            owner_d = win_oth[IW-1:0];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (HReady) begin
      grant_d  = (state_d == OWN) ? (NUM_MASTERS'(1) << owner_d) : '0;
      mlock_d  = (state_d == OWN) && HLock[owner_d];
      master_d = (|grant_q) ? owner_q : IW'(DEFAULT_MASTER);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= IW'(NUM_MASTERS - 1);
      hold_q   <= '0;
      grant_q  <= '0;
      master_q <= IW'(DEFAULT_MASTER);
      mlock_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      mlock_q  <= mlock_d;
    end
  end

  assign HGrant    = grant_q;
  assign HMaster   = master_q;
  assign HMastLock = mlock_q;
  assign arb_busy  = (state_q == OWN) && HReq[owner_q];

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed scenarios followed by random traffic.
// Expected outputs come from an integer-level model of the arbitration rules.
// A monitor pops one expectation per clock and compares all outputs.
module tb_ahb_bus_arbiter;

  localparam int N   = 3;
  localparam int MH  = 4;
  localparam int DEF = 0;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           HReq, HLock;
  logic                   HReady;
  logic [1:0]             HResp;
  logic [N-1:0]           HGrant;
  logic [$clog2(N)-1:0]   HMaster;
  logic                   HMastLock;
  logic                   arb_busy;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MH), .DEFAULT_MASTER(DEF)) dut (
    .clk(clk), .rst(rst), .HReq(HReq), .HLock(HLock), .HReady(HReady), .HResp(HResp),
    .HGrant(HGrant), .HMaster(HMaster), .HMastLock(HMastLock), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int grant;
    int master;
    int mlock;
    int busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: owner as an integer (-1 = bus parked), error flag, hold count.
  int m_own    = -1;
  int m_err    = 0;
  int m_hold   = 0;
  int m_last   = N - 1;
  int m_master = DEF;
  int m_mlock  = 0;

  function automatic int bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0] ? 1 : 0;
  endfunction

  function automatic int m_pick(input logic [N-1:0] req, input int excl, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (bit_of(req, j) == 1 && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input bit r, input logic [N-1:0] req, input logic [N-1:0] lk,
                            input bit rd, input logic [1:0] rs);
    int start, h, others, nxt_master;
`ifdef ARB_ROUND_ROBIN_EN
    start = (m_last + 1) % N;
`else
    start = 0;
`endif
    if (r) begin
      m_own = -1; m_err = 0; m_hold = 0; m_last = N - 1; m_master = DEF; m_mlock = 0;
    end else if (!rd) begin
      if (m_own >= 0 && m_err == 0 && rs == 2'b01) m_err = 1;
    end else begin
      nxt_master = (m_own >= 0) ? m_own : DEF;
      if (m_own < 0) begin
        m_own  = m_pick(req, -1, start);
        m_hold = 0;
      end else if (m_err == 1) begin
        m_err  = 0;
        m_hold = 0;
        m_own  = m_pick(req, m_own, start);
      end else begin
        others = (m_pick(req, m_own, 0) >= 0) ? 1 : 0;
        h = (m_hold + 1 > MH) ? MH : m_hold + 1;
        if (bit_of(lk, m_own) == 1) begin
          m_hold = others ? h : 0;
        end else if (bit_of(req, m_own) == 0) begin
          m_hold = 0;
          m_own  = m_pick(req, -1, start);
        end else if (others == 1 && h == MH) begin
          m_hold = 0;
          m_own  = m_pick(req, m_own, start);
        end else begin
          m_hold = others ? h : 0;
        end
      end
      if (m_own >= 0) m_last = m_own;
      m_master = nxt_master;
      m_mlock  = (m_own >= 0) ? bit_of(lk, m_own) : 0;
    end
  endtask

  // Apply one cycle of inputs and queue the response expected after the next edge.
  task automatic drive(input bit r, input logic [N-1:0] req, input logic [N-1:0] lk,
                       input bit rd, input logic [1:0] rs);
    exp_t e;
    rst = r; HReq = req; HLock = lk; HReady = rd; HResp = rs;
    model_step(r, req, lk, rd, rs);
    e.grant  = (m_own >= 0) ? (1 << m_own) : 0;
    e.master = m_master;
    e.mlock  = m_mlock;
    e.busy   = (m_own >= 0 && m_err == 0) ? bit_of(req, m_own) : 0;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  // Monitor: one expectation per clock, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hgrant",    int'(HGrant),    e.grant);
        chk("hmaster",   int'(HMaster),   e.master);
        chk("hmastlock", int'(HMastLock), e.mlock);
        chk("arb_busy",  int'(arb_busy),  e.busy);
      end
    end
  end

  initial begin
    logic [N-1:0] rq, lk;
    bit           rd;
    logic [1:0]   rs;
    // Reset then idle
    repeat (2)  drive(1, 3'b000, 3'b000, 1, 2'b00);
    repeat (10) drive(0, 3'b000, 3'b000, 1, 2'b00);
    // Single request from master 1, then release
    repeat (7)  drive(0, 3'b010, 3'b000, 1, 2'b00);
    repeat (3)  drive(0, 3'b000, 3'b000, 1, 2'b00);
    // Contention: master 0 wins, releases while HReady=0 for 3 cycles
    repeat (3)  drive(0, 3'b011, 3'b000, 1, 2'b00);
    repeat (3)  drive(0, 3'b010, 3'b000, 0, 2'b00);
    repeat (3)  drive(0, 3'b010, 3'b000, 1, 2'b00);
    repeat (2)  drive(0, 3'b000, 3'b000, 1, 2'b00);
    // Starvation limit with continuous contention
    repeat (20) drive(0, 3'b011, 3'b000, 1, 2'b00);
    repeat (2)  drive(0, 3'b000, 3'b000, 1, 2'b00);
    // Locked owner (master 1) ignores the hold limit, then unlocks
    repeat (2)  drive(0, 3'b010, 3'b010, 1, 2'b00);
    repeat (30) drive(0, 3'b011, 3'b010, 1, 2'b00);
    repeat (3)  drive(0, 3'b011, 3'b000, 1, 2'b00);
    repeat (2)  drive(0, 3'b000, 3'b000, 1, 2'b00);
    // Two-cycle ERROR response moves the grant off the owner
    repeat (2)  drive(0, 3'b001, 3'b000, 1, 2'b00);
    drive(0, 3'b011, 3'b000, 0, 2'b01);
    drive(0, 3'b011, 3'b000, 1, 2'b01);
    repeat (3)  drive(0, 3'b011, 3'b000, 1, 2'b00);
    // Reset mid-transfer
    drive(0, 3'b011, 3'b000, 0, 2'b00);
    drive(1, 3'b011, 3'b000, 0, 2'b00);
    repeat (3)  drive(0, 3'b011, 3'b000, 1, 2'b00);
    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rq = N'($urandom_range(0, (1 << N) - 1));
      lk = ($urandom_range(0, 3) == 0) ? (rq & N'($urandom_range(0, (1 << N) - 1))) : '0;
      rd = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
      drive(($urandom_range(0, 199) == 0), rq, lk, rd, rs);
    end
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Shares the single AHB bus between the CPU's bus-master wrappers: master 0 is the instruction-memory wrapper, master 1 is the data-memory wrapper, and further masters are optional.
- Samples each master's HReq/HLock and drives a one-hot HGrant back to the wrappers.
- Drives HMaster/HMastLock to the address/data muxes and slaves.
- Re-arbitration happens only at transfer boundaries (HReady=1). A hold counter prevents one unlocked master from starving the others.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8); index 0 is the instruction-memory wrapper.
- MAX_HOLD, 16, maximum consecutive HReady=1 cycles an unlocked owner keeps the bus while another master is requesting.
- DEFAULT_MASTER, 0, master index the bus is parked on when nobody requests.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- HReq  input  NUM_MASTERS  bus request per master
- HLock  input  NUM_MASTERS  locked-transfer request per master
- HReady  input  1  transfer-complete from selected slave
- HResp  input  2  slave response (00 OKAY, 01 ERROR)
- HGrant  output  NUM_MASTERS  one-hot grant, registered
- HMaster  output  $clog2(NUM_MASTERS)  index of current data-phase owner, registered
- HMastLock  output  1  current owner holds a locked grant, registered
- arb_busy  output  1  an owner with active HReq is holding the bus

Behaviour:
- Reset (rst=1 at posedge), sampled synchronously:
  - HGrant=0, HMaster=DEFAULT_MASTER, HMastLock=0, arb_busy=0, hold counter=0.
  - FSM to IDLE.
  - Applies mid-transfer with no drain.
- FSM states:
  - IDLE: no grant. If any HReq=1, grant the winner at the next posedge and go to OWN. Otherwise stay in IDLE with HGrant=0; the bus is parked and HMaster=DEFAULT_MASTER.
  - OWN: HGrant one-hot on owner. Re-arbitration is evaluated only on a posedge with HReady=1.
    - Owner HReq=0 and HLock=0: pick a new winner; go to IDLE if none.
    - Owner HLock=1: keep the owner regardless of other requests and of the hold counter; HMastLock=1.
    - Hold counter reaches MAX_HOLD with another HReq=1 and no lock: hand over to the next winner.
    - Otherwise keep the owner.
  - ERR: entered when HResp=01 with HReady=0 (first ERROR cycle). Grant is held. On the next HReady=1, force re-arbitration as if the owner had released the bus. This covers the 2-cycle ERROR response.
- Winner selection: fixed priority, lowest index wins. Master 0 (instruction fetch) beats master 1.
- Grant latency: HReq rise in IDLE gives HGrant one cycle later. A handover in OWN takes effect on the posedge where HReady=1 is sampled.
- HMaster updates one HReady=1 cycle after HGrant changes, so it tracks the data-phase owner.
- HGrant is always one-hot or zero. No grant is ever given to a master with HReq=0, except for DEFAULT_MASTER parking, which gives no HGrant.
- Hold counter:
  - Increments on each HReady=1 cycle in OWN while another HReq is pending.
  - Saturates at MAX_HOLD.
  - Clears on a grant change or when no other requester is pending.
- HReady=0: all grant/owner state is frozen, including the counter.
- Simultaneous events at an HReady=1 edge:
  - Owner release plus other requests: the new winner is granted that same edge.
  - HLock asserted on the same edge the hold limit is hit: the lock wins.
- arb_busy = (state==OWN) & HReq[owner].

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: winner selection is round-robin, starting at the index after the last owner and wrapping NUM_MASTERS-1 to 0. Lock and hold rules are unchanged.
- Undefined: fixed priority, lowest index wins.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all HReq=0, HReady=1 -> HGrant=00, HMaster=0, HMastLock=0 for 10 cycles.
- Single request: HReq=10 at cycle 5 -> HGrant=10 at cycle 6, HMaster=1 at cycle 7. Drop HReq at cycle 12 -> HGrant=00 at cycle 13.
- Contention: HReq=11 in IDLE -> HGrant=01. Owner 0 releases with HReady=1 -> HGrant=10 the next cycle. HReady=0 for 3 cycles delays the handover by 3 cycles.
- Starvation limit: MAX_HOLD=4, HReq=11 continuous, HReady=1 -> master 1 is granted after 4 owner cycles. Under ARB_ROUND_ROBIN_EN the grant alternates 01,10 every 4 cycles.
- Lock: master 1 owns with HLock=10 and HReq=11 for 30 cycles -> HGrant stays 10 and HMastLock=1 throughout. Release lock -> HGrant=01 at the next HReady=1 edge.
- Error and reset: HResp=01 with HReady=0, then 01 with HReady=1 -> grant moves to the other requester. Assert rst mid-transfer -> HGrant=00 next cycle.
